ssem_controller: RTL and testbench
==================================

SSEM_CONTROLLER -- requirements
Module: ssem_controller

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, max cycles mem_req waits for mem_ack before fault.
REQ-002 SHALL have ports: clk  in  1  system clock, all state changes on rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 start  in  1  leave HALT and begin execution; ignored when not halted.
REQ-005 stop_req  in  1  halt at next instruction boundary.
REQ-006 opcode  in  3  PI bits 15:13 from datapath (000 JMP, 001 JRP, 010 LDN, 011 STO, 100/101 SUB, 110 CMP, 111 STP).
REQ-007 acc_negative  in  1  accumulator bit 31.
REQ-008 mem_ack  in  1  memory access complete this cycle.
REQ-009 mem_req / mem_we / addr_sel  out  1 each  memory request, write enable, address source (0 = CI, 1 = PI operand).
REQ-010 ci_inc / ci_load / ci_add  out  1 each  CI += 1, CI <= bus, CI <= CI + bus.
REQ-011 pi_load / acc_load_neg / acc_sub  out  1 each  PI <= bus, ACC <= -bus, ACC <= ACC - bus.
REQ-012 acc_to_bus / mem_to_bus  out  1 each  bus driver enables.
REQ-013 halted / fault  out  1 each  controller in HALT; memory timeout occurred.
REQ-014 instr_count  out  16  decoded-instruction counter.

Function
REQ-015 States SHALL be HALT, INC, FETCH, DECODE, EXEC.
REQ-016 HALT: all strobes 0, halted=1; start=1 -> INC, clears fault; start ignored in all other states.
REQ-017 INC: ci_inc=1 for one cycle -> FETCH; if stop_req=1 on entry to INC, SHALL go HALT instead without asserting ci_inc.
REQ-018 FETCH: mem_req=1, addr_sel=0, mem_we=0 held until mem_ack=1; in the ack cycle mem_to_bus=1 and pi_load=1 (Mealy), -> DECODE next cycle.
REQ-019 mem_ack SHALL be honoured in the first cycle mem_req is high (zero-wait memory supported); mem_ack while mem_req=0 SHALL be ignored.
REQ-020 DECODE: one cycle, no strobes; instr_count += 1 (wraps FFFF -> 0000); opcode 111 -> HALT, else -> EXEC.
REQ-021 EXEC memory ops (JMP, JRP, LDN, SUB): mem_req=1, addr_sel=1 until mem_ack; in ack cycle mem_to_bus=1 plus ci_load (JMP), ci_add (JRP), acc_load_neg (LDN) or acc_sub (100/101); -> INC.
REQ-022 EXEC STO: mem_req=1, mem_we=1, addr_sel=1, acc_to_bus=1 held until and including ack cycle; -> INC.
REQ-023 EXEC CMP: one cycle, ci_inc=acc_negative, no mem_req; -> INC.
REQ-024 acc_to_bus and mem_to_bus SHALL never both be 1; no datapath strobe SHALL be asserted outside the cycles listed above.
REQ-025 Minimum instruction time with zero-wait memory: 4 cycles (INC, FETCH, DECODE, EXEC); STP takes 3 then HALT.
REQ-026 Timeout counter SHALL count consecutive mem_req cycles without ack; reaching MEM_TIMEOUT -> HALT, fault=1, mem_req dropped next cycle, no strobe issued for that access.
REQ-027 stop_req arriving mid-instruction SHALL NOT abort the in-flight access; instruction completes, then REQ-017 applies.
REQ-028 start and stop_req both 1 in HALT: start wins, INC entered; stop_req still 1 at INC then halts (no ci_inc).

Reset
REQ-029 reset=1 at a rising edge SHALL force HALT from any state, including mid-access: halted=1, fault=0, instr_count=0, all other outputs 0 the following cycle.
REQ-030 After reset deassertion controller SHALL remain in HALT until start.

Verification
REQ-031 Reset then start, zero-wait memory, opcodes LDN, SUB, STO, STP -> strobes per REQ-021/022 in cycles 4, 8, 12; halted=1 after cycle 15; instr_count=4.
REQ-032 Fetch with mem_ack delayed 3 cycles -> mem_req high exactly 4 cycles, pi_load pulses once in the 4th.
REQ-033 CMP with acc_negative=1 -> ci_inc in EXEC plus INC (2 total); acc_negative=0 -> 1.
REQ-034 mem_ack never asserted, MEM_TIMEOUT=15 -> fault=1, halted=1 after 15 mem_req cycles; next start clears fault.
REQ-035 reset asserted during STO wait -> mem_req, mem_we, acc_to_bus all 0 next cycle, instr_count=0.
REQ-036 stop_req pulsed during JMP EXEC wait -> ci_load still issued on ack, HALT entered with no further ci_inc; every cycle checks acc_to_bus & mem_to_bus == 0.

Source files
------------

// File: rtl/ssem_controller.sv
// SSEM (Manchester Baby) sequencing controller: INC/FETCH/DECODE/EXEC cycle with
// memory handshake, access timeout, instruction counter and clean halt on stop_req.
module ssem_controller #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop_req,
  input  logic [2:0]  opcode,
  input  logic        acc_negative,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ci_inc,
  output logic        ci_load,
  output logic        ci_add,
  output logic        pi_load,
  output logic        acc_load_neg,
  output logic        acc_sub,
  output logic        acc_to_bus,
  output logic        mem_to_bus,
  output logic        halted,
  output logic        fault,
  output logic [15:0] instr_count
);

  localparam logic [2:0] StHalt   = 3'd0;
  localparam logic [2:0] StInc    = 3'd1;
  localparam logic [2:0] StFetch  = 3'd2;
  localparam logic [2:0] StDecode = 3'd3;
  localparam logic [2:0] StExec   = 3'd4;

  localparam logic [2:0] OpJmp = 3'b000;
  localparam logic [2:0] OpJrp = 3'b001;
  localparam logic [2:0] OpLdn = 3'b010;
  localparam logic [2:0] OpSto = 3'b011;
  localparam logic [2:0] OpCmp = 3'b110;
  localparam logic [2:0] OpStp = 3'b111;

  localparam int unsigned TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TLast = TW'(MEM_TIMEOUT - 1);

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] timeout_q, timeout_d;
  logic [15:0]   count_q, count_d;
  logic          fault_q, fault_d;
  logic          stop_q, stop_d;

  always_comb begin
    state_d      = state_q;
    timeout_d    = '0;
    count_d      = count_q;
    fault_d      = fault_q;
    // A stop request seen at any point mid-instruction is honoured at the next INC.
    stop_d       = stop_q | stop_req;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    addr_sel     = 1'b0;
    ci_inc       = 1'b0;
    ci_load      = 1'b0;
    ci_add       = 1'b0;
    pi_load      = 1'b0;
    acc_load_neg = 1'b0;
    acc_sub      = 1'b0;
    acc_to_bus   = 1'b0;
    mem_to_bus   = 1'b0;

    case (state_q)
      StHalt: begin
        stop_d = 1'b0;
        if (start) begin
          state_d = StInc;
          fault_d = 1'b0;
        end
      end
      StInc: begin
        if (stop_req || stop_q) begin
          state_d = StHalt;
        end else begin
          ci_inc  = 1'b1;
          state_d = StFetch;
        end
      end
      StFetch: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          mem_to_bus = 1'b1;
          pi_load    = 1'b1;
          state_d    = StDecode;
        end
      end
      StDecode: begin
        count_d = count_q + 16'd1;
        state_d = (opcode == OpStp) ? StHalt : StExec;
      end
      StExec: begin
        if (opcode == OpCmp) begin
          ci_inc  = acc_negative;
          state_d = StInc;
        end else if (opcode == OpStp) begin
          state_d = StInc;
        end else begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          if (opcode == OpSto) begin
            mem_we     = 1'b1;
            acc_to_bus = 1'b1;
          end
          if (mem_ack) begin
            state_d = StInc;
            if (opcode != OpSto) begin
              mem_to_bus = 1'b1;
            end
            case (opcode)
              OpJmp:   ci_load      = 1'b1;
              OpJrp:   ci_add       = 1'b1;
              OpLdn:   acc_load_neg = 1'b1;
              OpSto:   ;
              default: acc_sub      = 1'b1;
            endcase
          end
        end
      end
      default: state_d = StHalt;
    endcase

    // Consecutive un-acked request cycles; the last allowed cycle can still be acked.
    if (mem_req && !mem_ack) begin
      if (timeout_q == TLast) begin
        state_d = StHalt;
        fault_d = 1'b1;
      end else begin
        timeout_d = timeout_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StHalt;
      timeout_q <= '0;
      count_q   <= '0;
      fault_q   <= 1'b0;
      stop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_d;
      count_q   <= count_d;
      fault_q   <= fault_d;
      stop_q    <= stop_d;
    end
  end

  assign halted      = (state_q == StHalt);
  assign fault       = fault_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_ssem_controller.sv
// Directed bench for ssem_controller: per-cycle vector table plus hand-written
// sequences for wait states, timeout, reset mid-access and stop handling.
module tb_ssem_controller;

  localparam logic [2:0] OP_JMP  = 3'b000;
  localparam logic [2:0] OP_JRP  = 3'b001;
  localparam logic [2:0] OP_LDN  = 3'b010;
  localparam logic [2:0] OP_STO  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_SUB2 = 3'b101;
  localparam logic [2:0] OP_CMP  = 3'b110;
  localparam logic [2:0] OP_STP  = 3'b111;

  localparam logic [12:0] B_NONE  = 13'h0000;
  localparam logic [12:0] B_MREQ  = 13'h1000;
  localparam logic [12:0] B_WE    = 13'h0800;
  localparam logic [12:0] B_ASEL  = 13'h0400;
  localparam logic [12:0] B_CIINC = 13'h0200;
  localparam logic [12:0] B_CILD  = 13'h0100;
  localparam logic [12:0] B_CIADD = 13'h0080;
  localparam logic [12:0] B_PILD  = 13'h0040;
  localparam logic [12:0] B_LDN   = 13'h0020;
  localparam logic [12:0] B_SUB   = 13'h0010;
  localparam logic [12:0] B_A2B   = 13'h0008;
  localparam logic [12:0] B_M2B   = 13'h0004;
  localparam logic [12:0] B_HALT  = 13'h0002;
  localparam logic [12:0] B_FAULT = 13'h0001;
  localparam logic [12:0] B_FETCH = B_MREQ | B_PILD | B_M2B;

  typedef struct {
    logic        start;
    logic        stop;
    logic [2:0]  op;
    logic        accn;
    logic        ack;
    logic [12:0] exp;
    logic [15:0] cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, start, stop_req, acc_negative, mem_ack;
  logic [2:0]  opcode;
  logic        mem_req, mem_we, addr_sel, ci_inc, ci_load, ci_add, pi_load;
  logic        acc_load_neg, acc_sub, acc_to_bus, mem_to_bus, halted, fault;
  logic [15:0] instr_count;
  logic [12:0] outs;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign outs = {mem_req, mem_we, addr_sel, ci_inc, ci_load, ci_add, pi_load,
                 acc_load_neg, acc_sub, acc_to_bus, mem_to_bus, halted, fault};

  ssem_controller #(.MEM_TIMEOUT(15)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stop_req     (stop_req),
    .opcode       (opcode),
    .acc_negative (acc_negative),
    .mem_ack      (mem_ack),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .addr_sel     (addr_sel),
    .ci_inc       (ci_inc),
    .ci_load      (ci_load),
    .ci_add       (ci_add),
    .pi_load      (pi_load),
    .acc_load_neg (acc_load_neg),
    .acc_sub      (acc_sub),
    .acc_to_bus   (acc_to_bus),
    .mem_to_bus   (mem_to_bus),
    .halted       (halted),
    .fault        (fault),
    .instr_count  (instr_count)
  );

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Drive one cycle's inputs, then settle to the falling edge for sampling.
  task automatic apply(input logic rs, input logic st, input logic sp, input logic [2:0] op,
                       input logic an, input logic ak);
    reset        = rs;
    start        = st;
    stop_req     = sp;
    opcode       = op;
    acc_negative = an;
    mem_ack      = ak;
    @(negedge clk);
    chk("bus_excl", {15'b0, acc_to_bus & mem_to_bus}, 16'h0);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic st, input logic sp, input logic [2:0] op,
                              input logic an, input logic ak, input logic [12:0] e,
                              input logic [15:0] c);
    vec_t v;
    v.start = st; v.stop = sp; v.op = op; v.accn = an; v.ack = ak; v.exp = e; v.cnt = c;
    return v;
  endfunction

  // From HALT with fault clear: start, INC, zero-wait FETCH, DECODE of op.
  task automatic to_exec(input logic [2:0] op);
    apply(1'b0, 1'b1, 1'b0, op, 1'b0, 1'b0); chk("pre_halt", {3'b0, outs}, {3'b0, B_HALT});
    adv();
    apply(1'b0, 1'b0, 1'b0, op, 1'b0, 1'b0); chk("pre_inc", {3'b0, outs}, {3'b0, B_CIINC});
    adv();
    apply(1'b0, 1'b0, 1'b0, op, 1'b0, 1'b1); chk("pre_fetch", {3'b0, outs}, {3'b0, B_FETCH});
    adv();
    apply(1'b0, 1'b0, 1'b0, op, 1'b0, 1'b0); chk("pre_decode", {3'b0, outs}, {3'b0, B_NONE});
    adv();
  endtask

  initial begin
    vec_t q[$];

    reset = 1'b1; start = 1'b0; stop_req = 1'b0; opcode = OP_JMP;
    acc_negative = 1'b0; mem_ack = 1'b0;
    repeat (2) begin
      apply(1'b1, 1'b0, 1'b0, OP_JMP, 1'b0, 1'b0);
      adv();
    end

    // Idle after reset: stays halted, stray mem_ack ignored.
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b0, 1'b0, OP_JMP, 1'b0, 1'b1);
      chk($sformatf("reset_idle%0d", i), {3'b0, outs}, {3'b0, B_HALT});
      chk($sformatf("reset_cnt%0d", i), instr_count, 16'd0);
      adv();
    end

    q.push_back(mk(1'b1, 1'b0, OP_JMP,  1'b0, 1'b0, B_HALT, 16'd0));
    q.push_back(mk(1'b0, 1'b0, OP_JMP,  1'b0, 1'b0, B_CIINC, 16'd0));
    q.push_back(mk(1'b0, 1'b0, OP_LDN,  1'b0, 1'b1, B_FETCH, 16'd0));
    q.push_back(mk(1'b0, 1'b0, OP_LDN,  1'b0, 1'b0, B_NONE, 16'd0));
    q.push_back(mk(1'b0, 1'b0, OP_LDN,  1'b0, 1'b1, B_MREQ | B_ASEL | B_M2B | B_LDN, 16'd1));
    q.push_back(mk(1'b0, 1'b0, OP_SUB,  1'b0, 1'b0, B_CIINC, 16'd1));
    q.push_back(mk(1'b0, 1'b0, OP_SUB,  1'b0, 1'b1, B_FETCH, 16'd1));
    q.push_back(mk(1'b0, 1'b0, OP_SUB,  1'b0, 1'b0, B_NONE, 16'd1));
    q.push_back(mk(1'b0, 1'b0, OP_SUB,  1'b0, 1'b1, B_MREQ | B_ASEL | B_M2B | B_SUB, 16'd2));
    q.push_back(mk(1'b0, 1'b0, OP_STO,  1'b0, 1'b0, B_CIINC, 16'd2));
    q.push_back(mk(1'b0, 1'b0, OP_STO,  1'b0, 1'b1, B_FETCH, 16'd2));
    q.push_back(mk(1'b0, 1'b0, OP_STO,  1'b0, 1'b0, B_NONE, 16'd2));
    q.push_back(mk(1'b0, 1'b0, OP_STO,  1'b0, 1'b1, B_MREQ | B_WE | B_ASEL | B_A2B, 16'd3));
    q.push_back(mk(1'b0, 1'b0, OP_STP,  1'b0, 1'b0, B_CIINC, 16'd3));
    q.push_back(mk(1'b0, 1'b0, OP_STP,  1'b0, 1'b1, B_FETCH, 16'd3));
    q.push_back(mk(1'b0, 1'b0, OP_STP,  1'b0, 1'b0, B_NONE, 16'd3));
    q.push_back(mk(1'b0, 1'b0, OP_STP,  1'b0, 1'b0, B_HALT, 16'd4));
    q.push_back(mk(1'b1, 1'b0, OP_JRP,  1'b0, 1'b0, B_HALT, 16'd4));
    q.push_back(mk(1'b0, 1'b0, OP_JRP,  1'b0, 1'b0, B_CIINC, 16'd4));
    q.push_back(mk(1'b0, 1'b0, OP_JRP,  1'b0, 1'b1, B_FETCH, 16'd4));
    q.push_back(mk(1'b0, 1'b0, OP_JRP,  1'b0, 1'b0, B_NONE, 16'd4));
    q.push_back(mk(1'b0, 1'b0, OP_JRP,  1'b0, 1'b1, B_MREQ | B_ASEL | B_M2B | B_CIADD, 16'd5));
    q.push_back(mk(1'b0, 1'b0, OP_CMP,  1'b0, 1'b0, B_CIINC, 16'd5));
    q.push_back(mk(1'b0, 1'b0, OP_CMP,  1'b0, 1'b1, B_FETCH, 16'd5));
    q.push_back(mk(1'b0, 1'b0, OP_CMP,  1'b0, 1'b0, B_NONE, 16'd5));
    q.push_back(mk(1'b0, 1'b0, OP_CMP,  1'b1, 1'b1, B_CIINC, 16'd6));
    q.push_back(mk(1'b0, 1'b0, OP_CMP,  1'b1, 1'b0, B_CIINC, 16'd6));
    q.push_back(mk(1'b0, 1'b0, OP_CMP,  1'b0, 1'b1, B_FETCH, 16'd6));
    q.push_back(mk(1'b0, 1'b0, OP_CMP,  1'b0, 1'b0, B_NONE, 16'd6));
    q.push_back(mk(1'b0, 1'b0, OP_CMP,  1'b0, 1'b1, B_NONE, 16'd7));
    q.push_back(mk(1'b0, 1'b0, OP_SUB2, 1'b0, 1'b0, B_CIINC, 16'd7));
    q.push_back(mk(1'b0, 1'b0, OP_SUB2, 1'b0, 1'b1, B_FETCH, 16'd7));
    q.push_back(mk(1'b0, 1'b0, OP_SUB2, 1'b0, 1'b0, B_NONE, 16'd7));
    q.push_back(mk(1'b0, 1'b0, OP_SUB2, 1'b0, 1'b1, B_MREQ | B_ASEL | B_M2B | B_SUB, 16'd8));
    q.push_back(mk(1'b0, 1'b1, OP_SUB2, 1'b0, 1'b0, B_NONE, 16'd8));
    q.push_back(mk(1'b0, 1'b0, OP_SUB2, 1'b0, 1'b0, B_HALT, 16'd8));

    foreach (q[i]) begin
      apply(1'b0, q[i].start, q[i].stop, q[i].op, q[i].accn, q[i].ack);
      chk($sformatf("vec%0d_out", i), {3'b0, outs}, {3'b0, q[i].exp});
      chk($sformatf("vec%0d_cnt", i), instr_count, q[i].cnt);
      adv();
    end

    // Fetch with three wait cycles: mem_req for exactly four cycles, pi_load in the last.
    apply(1'b0, 1'b1, 1'b0, OP_STP, 1'b0, 1'b0); adv();
    apply(1'b0, 1'b0, 1'b0, OP_STP, 1'b0, 1'b0);
    chk("wait_inc", {3'b0, outs}, {3'b0, B_CIINC});
    adv();
    for (int k = 0; k < 4; k++) begin
      apply(1'b0, 1'b0, 1'b0, OP_STP, 1'b0, k == 3);
      chk($sformatf("wait_mreq%0d", k), {15'b0, mem_req}, 16'd1);
      chk($sformatf("wait_pild%0d", k), {15'b0, pi_load}, {15'b0, k == 3});
      adv();
    end
    apply(1'b0, 1'b0, 1'b0, OP_STP, 1'b0, 1'b0);
    chk("wait_decode", {3'b0, outs}, {3'b0, B_NONE});
    adv();
    apply(1'b0, 1'b0, 1'b0, OP_STP, 1'b0, 1'b0);
    chk("wait_halt", {3'b0, outs}, {3'b0, B_HALT});
    chk("wait_cnt", instr_count, 16'd9);
    adv();

    // Memory never acks: fault after 15 request cycles, restart clears it.
    apply(1'b0, 1'b1, 1'b0, OP_JMP, 1'b0, 1'b0); adv();
    apply(1'b0, 1'b0, 1'b0, OP_JMP, 1'b0, 1'b0); adv();
    for (int k = 0; k < 15; k++) begin
      apply(1'b0, 1'b0, 1'b0, OP_JMP, 1'b0, 1'b0);
      chk($sformatf("tmo_wait%0d", k), {3'b0, outs}, {3'b0, B_MREQ});
      adv();
    end
    apply(1'b0, 1'b0, 1'b0, OP_JMP, 1'b0, 1'b1);
    chk("tmo_fault", {3'b0, outs}, {3'b0, B_HALT | B_FAULT});
    adv();
    apply(1'b0, 1'b1, 1'b0, OP_JMP, 1'b0, 1'b0);
    chk("tmo_start", {3'b0, outs}, {3'b0, B_HALT | B_FAULT});
    adv();
    apply(1'b0, 1'b0, 1'b0, OP_JMP, 1'b0, 1'b0);
    chk("tmo_clear", {3'b0, outs}, {3'b0, B_CIINC});
    adv();
    apply(1'b1, 1'b0, 1'b0, OP_JMP, 1'b0, 1'b0); adv();
    apply(1'b0, 1'b0, 1'b0, OP_JMP, 1'b0, 1'b0);
    chk("tmo_rst_out", {3'b0, outs}, {3'b0, B_HALT});
    chk("tmo_rst_cnt", instr_count, 16'd0);
    adv();

    // Reset in the middle of a store wait.
    to_exec(OP_STO);
    for (int k = 0; k < 2; k++) begin
      apply(1'b0, 1'b0, 1'b0, OP_STO, 1'b0, 1'b0);
      chk($sformatf("sto_wait%0d", k), {3'b0, outs}, {3'b0, B_MREQ | B_WE | B_ASEL | B_A2B});
      chk($sformatf("sto_cnt%0d", k), instr_count, 16'd1);
      adv();
    end
    apply(1'b1, 1'b0, 1'b0, OP_STO, 1'b0, 1'b0); adv();
    apply(1'b0, 1'b0, 1'b0, OP_STO, 1'b0, 1'b0);
    chk("sto_rst_out", {3'b0, outs}, {3'b0, B_HALT});
    chk("sto_rst_cnt", instr_count, 16'd0);
    adv();

    // Stop pulse during a JMP wait: jump completes, then halt without ci_inc.
    to_exec(OP_JMP);
    apply(1'b0, 1'b0, 1'b1, OP_JMP, 1'b0, 1'b0);
    chk("jmp_wait0", {3'b0, outs}, {3'b0, B_MREQ | B_ASEL});
    adv();
    apply(1'b0, 1'b0, 1'b0, OP_JMP, 1'b0, 1'b0);
    chk("jmp_wait1", {3'b0, outs}, {3'b0, B_MREQ | B_ASEL});
    adv();
    apply(1'b0, 1'b0, 1'b0, OP_JMP, 1'b0, 1'b1);
    chk("jmp_ack", {3'b0, outs}, {3'b0, B_MREQ | B_ASEL | B_M2B | B_CILD});
    adv();
    apply(1'b0, 1'b0, 1'b0, OP_JMP, 1'b0, 1'b0);
    chk("jmp_inc", {3'b0, outs}, {3'b0, B_NONE});
    adv();
    apply(1'b0, 1'b0, 1'b0, OP_JMP, 1'b0, 1'b0);
    chk("jmp_halt", {3'b0, outs}, {3'b0, B_HALT});
    chk("jmp_cnt", instr_count, 16'd1);
    adv();

    // start and stop_req together: start wins, then halts at INC.
    apply(1'b0, 1'b1, 1'b1, OP_JMP, 1'b0, 1'b0);
    chk("both_halt", {3'b0, outs}, {3'b0, B_HALT});
    adv();
    apply(1'b0, 1'b0, 1'b1, OP_JMP, 1'b0, 1'b0);
    chk("both_inc", {3'b0, outs}, {3'b0, B_NONE});
    adv();
    apply(1'b0, 1'b0, 1'b0, OP_JMP, 1'b0, 1'b0);
    chk("both_rehalt", {3'b0, outs}, {3'b0, B_HALT});
    adv();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
